// File: rtl/bus_mem_resp.sv
// Byte memory with a bus port and a program loader.
// Optional macro MEM_ROM_PROTECT_EN blocks bus writes below RAM_BASE.
module bus_mem_resp #(
  parameter int              ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'('h1800)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  inout  wire  [7:0]        data,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              bus_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_rdata;
  logic              r_wr_q;
  logic              r_bus_err;
  logic              r_load_ready;
  logic              r_cpu_hold;
  logic              r_load_done;

  logic w_idle;
  logic w_rd_ok;
  logic w_conflict;
  logic w_wr_edge;
  logic w_rom_hit;
  logic w_bus_we;
  logic w_ld_we;
  logic w_err_set;

  // Bus is serviced only in IDLE and never while reset is held.
  assign w_idle     = (r_state == S_IDLE) & ~rst;
  assign w_rd_ok    = w_idle & rd & ~wr;
  assign w_conflict = w_idle & rd & wr;
  assign w_wr_edge  = w_idle & wr & ~r_wr_q & ~rd;

`ifdef MEM_ROM_PROTECT_EN
  assign w_rom_hit = (addr < RAM_BASE);
`else
  assign w_rom_hit = 1'b0;
`endif

  assign w_bus_we  = w_wr_edge & ~w_rom_hit;
  assign w_err_set = w_conflict | (w_wr_edge & w_rom_hit);
  assign w_ld_we   = (r_state == S_LOAD) & load_valid & ~rst;

  assign data = w_rd_ok ? r_rdata : 8'hzz;

  assign load_ready = r_load_ready;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign bus_err    = r_bus_err;

  // Shared array: loader and bus are mutually exclusive by state.
  always_ff @(posedge sys_clk) begin
    if (w_ld_we)
      r_mem[r_ptr] <= load_data;
    else if (w_bus_we)
      r_mem[addr] <= data;
  end

  // Read register, wr history and sticky error flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_rdata   <= 8'h00;
      r_wr_q    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_wr_q <= wr;
      if (w_rd_ok)
        r_rdata <= r_mem[addr];
      if (w_err_set)
        r_bus_err <= 1'b1;
    end
  end

  // Loader FSM with registered handshake outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_load_ready <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_load_ready <= 1'b1;
            r_cpu_hold   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            if (load_last || r_ptr == PTR_MAX) begin
              r_state      <= S_DONE;
              r_load_ready <= 1'b0;
              r_cpu_hold   <= 1'b0;
              r_load_done  <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_load_done <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
          r_cpu_hold   <= 1'b0;
          r_load_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_resp.sv
// Directed bench for bus_mem_resp: loader, bus reads/writes,
// protection, conflict, reset mid-load and pointer end stop.
module tb_bus_mem_resp;

  logic        clk;
  logic        rst;
  logic [12:0] addr;
  logic        rd;
  logic        wr;
  tri1  [7:0]  data;
  logic [7:0]  drv;
  logic        drv_en;
  logic        ls;
  logic        lv;
  logic [7:0]  ld;
  logic        ll;
  logic        lrdy;
  logic        hold;
  logic        ldone;
  logic        berr;

  int n_pass;
  int n_tot;

  assign data = drv_en ? drv : 8'hzz;

  bus_mem_resp dut (
    .sys_clk    (clk),
    .rst        (rst),
    .addr       (addr),
    .rd         (rd),
    .wr         (wr),
    .data       (data),
    .load_start (ls),
    .load_valid (lv),
    .load_data  (ld),
    .load_last  (ll),
    .load_ready (lrdy),
    .cpu_hold   (hold),
    .load_done  (ldone),
    .bus_err    (berr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wop;
    logic [12:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [12:0] a, input logic [7:0] d);
    addr = a; drv = d; drv_en = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; drv_en = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input string nm, input logic [12:0] a,
                        input logic [7:0] exp);
    addr = a; rd = 1'b1; wr = 1'b0;
    tick();
    chk(nm, {24'h0, data}, {24'h0, exp});
    rd = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    ls = 1'b1;
    tick();
    ls = 1'b0;
  endtask

  vec_t vt[7];
  logic [7:0] rom_exp;
  logic       err_exp;
  bit         early;

  initial begin
    n_pass = 0; n_tot = 0;
    rst = 1'b1; addr = '0; rd = 1'b1; wr = 1'b0;
    drv = '0; drv_en = 1'b0;
    ls = 1'b0; lv = 1'b0; ld = '0; ll = 1'b0;

    vt[0] = '{1'b0, 13'h0000, 8'h00, 8'hA5};
    vt[1] = '{1'b0, 13'h0001, 8'h00, 8'h3C};
    vt[2] = '{1'b0, 13'h0002, 8'h00, 8'h7E};
    vt[3] = '{1'b1, 13'h1810, 8'h12, 8'h00};
    vt[4] = '{1'b1, 13'h1900, 8'h11, 8'h00};
    vt[5] = '{1'b0, 13'h1810, 8'h00, 8'h12};
    vt[6] = '{1'b0, 13'h1900, 8'h00, 8'h11};

    tick(); tick();
    chk("rst_ready", {31'h0, lrdy}, 32'h0);
    chk("rst_hold",  {31'h0, hold}, 32'h0);
    chk("rst_done",  {31'h0, ldone}, 32'h0);
    chk("rst_err",   {31'h0, berr}, 32'h0);
    chk("rst_dataZ", {24'h0, data}, 32'hFF);
    rd = 1'b0;
    rst = 1'b0;
    tick();

    // Program load of three bytes.
    pulse_start();
    chk("ld_ready", {31'h0, lrdy}, 32'h1);
    chk("ld_hold0", {31'h0, hold}, 32'h1);
    lv = 1'b1; ld = 8'hA5; ll = 1'b0;
    tick();
    chk("ld_hold1", {31'h0, hold}, 32'h1);
    ld = 8'h3C;
    tick();
    chk("ld_hold2", {31'h0, hold}, 32'h1);
    ld = 8'h7E; ll = 1'b1;
    tick();
    lv = 1'b0; ll = 1'b0;
    chk("ld_done_hi", {31'h0, ldone}, 32'h1);
    tick();
    chk("ld_done_lo", {31'h0, ldone}, 32'h0);
    chk("ld_idle_hold", {31'h0, hold}, 32'h0);
    chk("ld_idle_rdy", {31'h0, lrdy}, 32'h0);

    // Table of bus reads and writes.
    for (int i = 0; i < 7; i++) begin
      if (vt[i].wop) bus_wr(vt[i].a, vt[i].wd);
      else bus_rd($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
    end

    // rd low: bus released.
    addr = 13'h0001; rd = 1'b1;
    tick();
    rd = 1'b0;
    #1;
    chk("rd0_dataZ", {24'h0, data}, 32'hFF);
    tick();

    // wr held high: single write only.
    addr = 13'h1805; drv = 8'h55; drv_en = 1'b1; wr = 1'b1;
    repeat (4) tick();
    drv = 8'hAA;
    tick();
    wr = 1'b0; drv_en = 1'b0;
    tick();
    bus_rd("ram_single", 13'h1805, 8'h55);

    // Write into the ROM region.
`ifdef MEM_ROM_PROTECT_EN
    rom_exp = 8'h7E; err_exp = 1'b1;
`else
    rom_exp = 8'hFF; err_exp = 1'b0;
`endif
    bus_wr(13'h0002, 8'hFF);
    chk("rom_err", {31'h0, berr}, {31'h0, err_exp});
    bus_rd("rom_data", 13'h0002, rom_exp);

    // rd and wr together.
    addr = 13'h1900; rd = 1'b1; wr = 1'b1;
    #1;
    chk("cfl_dataZ", {24'h0, data}, 32'hFF);
    tick();
    chk("cfl_err", {31'h0, berr}, 32'h1);
    wr = 1'b0;
    tick();
    drv = 8'hEE; drv_en = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0; drv_en = 1'b0;
    repeat (3) tick();
    bus_rd("cfl_nowr", 13'h1900, 8'h11);
    chk("cfl_sticky", {31'h0, berr}, 32'h1);

    // Reset in the middle of a load.
    pulse_start();
    lv = 1'b1; ld = 8'hB1;
    tick();
    ld = 8'hB2;
    tick();
    lv = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_hold", {31'h0, hold}, 32'h0);
    chk("mr_ready", {31'h0, lrdy}, 32'h0);
    chk("mr_err", {31'h0, berr}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    bus_rd("mr_b0", 13'h0000, 8'hB1);
    bus_rd("mr_b1", 13'h0001, 8'hB2);
    bus_rd("mr_b2", 13'h0002, rom_exp);
    pulse_start();
    chk("mr_restart", {31'h0, lrdy}, 32'h1);
    lv = 1'b1; ld = 8'hC7; ll = 1'b1;
    tick();
    lv = 1'b0; ll = 1'b0;
    chk("mr_done", {31'h0, ldone}, 32'h1);
    tick();
    bus_rd("mr_new", 13'h0000, 8'hC7);

    // Full-depth load without load_last stops at the top.
    early = 1'b0;
    pulse_start();
    lv = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      ld = 8'(i);
      if (ldone) early = 1'b1;
      tick();
    end
    lv = 1'b0;
    chk("end_early", {31'h0, early}, 32'h0);
    chk("end_done", {31'h0, ldone}, 32'h1);
    tick();
    chk("end_idle", {31'h0, hold}, 32'h0);
    bus_rd("end_top", 13'h1FFF, 8'hFF);
    bus_rd("end_low", 13'h0005, 8'h05);
    bus_rd("end_mid", 13'h1805, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
